// File: rtl/mux.sv
// Registered N:1 one-hot mux built five ways (ternary, case, if-else, loop, AND-OR tree).
// Optional MUX_CHECK_EN adds onehot_err_o: bad select or disagreement between the five paths.
module mux #(
  parameter int N = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] sel_i,
  output logic         y_ter_o,
  output logic         y_case_o,
  output logic         y_ifelse_o,
  output logic         y_loop_o,
`ifdef MUX_CHECK_EN
  output logic         onehot_err_o,
`endif
  output logic         y_aor_o
);

  localparam int P = (N <= 2) ? 2 : (1 << $clog2(N));

  logic         w_onehot;
  logic [N:0]   w_ter_chain;
  logic         w_ter;
  logic         w_case;
  logic         w_ifelse;
  logic         w_loop;
  logic         w_aor;
  logic [2*P-1:1] w_tree;

  logic r_ter, r_case, r_ifelse, r_loop, r_aor;

  assign w_onehot = (sel_i != '0) && ((sel_i & (sel_i - N'(1))) == '0);

  // Ternary chain: each stage matches one exact one-hot code, so zero/multi-hot falls to 0.
  assign w_ter_chain[N] = 1'b0;
  for (genvar k = 0; k < N; k++) begin : g_ter
    localparam logic [N-1:0] K_SEL = N'(1) << k;
    assign w_ter_chain[k] = (sel_i == K_SEL) ? a_i[k] : w_ter_chain[k+1];
  end
  assign w_ter = w_ter_chain[0];

  always_comb begin
    w_case = 1'b0;
    for (int k = 0; k < N; k++) begin
      case (sel_i)
        N'(1) << k: w_case = a_i[k];
        default:    ;
      endcase
    end
  end

  always_comb begin
    w_ifelse = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (sel_i == (N'(1) << k)) w_ifelse = a_i[k];
    end
  end

  always_comb begin
    w_loop = 1'b0;
    for (int k = 0; k < N; k++) w_loop = w_loop | (a_i[k] & sel_i[k]);
    w_loop = w_loop & w_onehot;
  end

  // AND-OR tree stored as a heap: leaves at P..2P-1, node i = child 2i | child 2i+1.
  for (genvar k = 0; k < P; k++) begin : g_leaf
    if (k < N) begin : g_used
      assign w_tree[P+k] = a_i[k] & sel_i[k];
    end else begin : g_pad
      assign w_tree[P+k] = 1'b0;
    end
  end
  for (genvar i = 1; i < P; i++) begin : g_node
    assign w_tree[i] = w_tree[2*i] | w_tree[2*i+1];
  end
  assign w_aor = w_tree[1] & w_onehot;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_ter    <= 1'b0;
      r_case   <= 1'b0;
      r_ifelse <= 1'b0;
      r_loop   <= 1'b0;
      r_aor    <= 1'b0;
    end else begin
      r_ter    <= w_ter;
      r_case   <= w_case;
      r_ifelse <= w_ifelse;
      r_loop   <= w_loop;
      r_aor    <= w_aor;
    end
  end

  assign y_ter_o    = r_ter;
  assign y_case_o   = r_case;
  assign y_ifelse_o = r_ifelse;
  assign y_loop_o   = r_loop;
  assign y_aor_o    = r_aor;

`ifdef MUX_CHECK_EN
  logic w_diff;
  logic r_err;

  // Any path disagreeing with the ternary reference means the paths are not all equal.
  assign w_diff = (w_ter ^ w_case) | (w_ter ^ w_ifelse) | (w_ter ^ w_loop) | (w_ter ^ w_aor);

  always_ff @(posedge clk_i) begin
    if (reset_i) r_err <= 1'b0;
    else         r_err <= ~w_onehot | w_diff;
  end

  assign onehot_err_o = r_err;
`endif

endmodule

// File: tb/tb_mux.sv
// Directed bench for mux: reset, stepped selects, zero/multi-hot selects, random one-hot
// traffic and a mid-stream reset. Checks onehot_err_o when MUX_CHECK_EN is defined.
module tb_mux;
  localparam int N = 4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [N-1:0] a_i;
  logic [N-1:0] sel_i;
  logic         y_ter_o, y_case_o, y_ifelse_o, y_loop_o, y_aor_o;
`ifdef MUX_CHECK_EN
  logic         onehot_err_o;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  mux #(.N(N)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .a_i          (a_i),
    .sel_i        (sel_i),
    .y_ter_o      (y_ter_o),
    .y_case_o     (y_case_o),
    .y_ifelse_o   (y_ifelse_o),
    .y_loop_o     (y_loop_o),
`ifdef MUX_CHECK_EN
    .onehot_err_o (onehot_err_o),
`endif
    .y_aor_o      (y_aor_o)
  );

  always #5 clk_i = ~clk_i;

  // All five outputs compared as one vector against a replicated expected bit.
  task automatic check_y(input string tag, input logic e);
    logic [4:0] obs;
    logic [4:0] exp;
    obs = {y_ter_o, y_case_o, y_ifelse_o, y_loop_o, y_aor_o};
    exp = {5{e}};
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: y{ter,case,ifelse,loop,aor} observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_err(input string tag, input logic e);
`ifdef MUX_CHECK_EN
    n_tot++;
    assert (onehot_err_o === e) n_pass++;
    else $error("FAIL %s: onehot_err_o observed %b expected %b", tag, onehot_err_o, e);
`else
    if (e === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic step(input logic rst, input logic [N-1:0] a, input logic [N-1:0] s);
    reset_i = rst;
    a_i     = a;
    sel_i   = s;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [N-1:0] a_r;
    int           k;
    logic         e;

    // 1. reset held for two edges, then release
    step(1'b1, 4'hF, 4'b0001); check_y("rst_edge1", 1'b0); check_err("rst_edge1_err", 1'b0);
    step(1'b1, 4'hF, 4'b0001); check_y("rst_edge2", 1'b0); check_err("rst_edge2_err", 1'b0);
    step(1'b0, 4'hF, 4'b0001); check_y("rst_release", 1'b1); check_err("rst_release_err", 1'b0);

    // 2. walk the select across a_i=1010
    step(1'b0, 4'b1010, 4'b0001); check_y("walk_s0", 1'b0);
    step(1'b0, 4'b1010, 4'b0010); check_y("walk_s1", 1'b1);
    step(1'b0, 4'b1010, 4'b0100); check_y("walk_s2", 1'b0);
    step(1'b0, 4'b1010, 4'b1000); check_y("walk_s3", 1'b1); check_err("walk_err", 1'b0);

    // 3/4. zero and multi-hot selects force 0
    step(1'b0, 4'hF, 4'b0000); check_y("sel_zero", 1'b0);  check_err("sel_zero_err", 1'b1);
    step(1'b0, 4'hF, 4'b0110); check_y("sel_multi", 1'b0); check_err("sel_multi_err", 1'b1);
    step(1'b0, 4'hF, 4'b1001); check_y("sel_ends", 1'b0);  check_err("sel_ends_err", 1'b1);
    step(1'b0, 4'hF, 4'b1111); check_y("sel_all", 1'b0);   check_err("sel_all_err", 1'b1);
    step(1'b0, 4'b0111, 4'b1000); check_y("sel_msb_lo", 1'b0); check_err("sel_msb_lo_err", 1'b0);
    step(1'b0, 4'b1000, 4'b1000); check_y("sel_msb_hi", 1'b1);

    // 5. random one-hot traffic
    for (int i = 0; i < 32; i++) begin
      a_r = N'($urandom);
      k   = int'($urandom_range(0, N-1));
      e   = a_r[k];
      step(1'b0, a_r, N'(1) << k);
      check_y($sformatf("rand%0d", i), e);
      check_err($sformatf("rand%0d_err", i), 1'b0);
    end

    // 6. random run with reset in cycle 10, released after one cycle
    for (int i = 0; i < 16; i++) begin
      a_r = N'($urandom) | 4'b0001;
      k   = int'($urandom_range(0, N-1));
      e   = (i == 10) ? 1'b0 : a_r[k];
      step(i == 10, a_r, N'(1) << k);
      check_y($sformatf("midrst%0d", i), e);
      check_err($sformatf("midrst%0d_err", i), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
